// File: rtl/switch_pkg.sv
// Shared types for the switch egress port: byte type, egress FSM states
// and the FIFO entry layout that carries the end-of-packet flag.
package switch_pkg;

    localparam int PORT_W = 8;

    typedef logic [PORT_W-1:0] byte_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        GAP
    } out_state_e;

    typedef struct packed {
        logic  last;
        byte_t data;
    } fifo_ent_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO.
// rdata always shows the head entry while the FIFO is non-empty.
// full/empty come from read/write pointers that carry one extra wrap bit.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage write; contents are only meaningful between the pointers.
    // NOTE: the storage array has no reset -- the pointers alone define what is valid,
    // and leaving the array unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Pointer update; both wrap naturally modulo 2*DEPTH.
    // NOTE: sequential state always uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_out_port.sv
// Switch egress port, store-and-forward.
// The fabric writes bytes into a FIFO. port_ready is advertised only while a
// complete packet is buffered. The reader then pulls one byte per port_read.
// Optional build macro SWITCH_OUT_PORT_STATS_EN adds the stat_pkts and
// stat_bytes counters and their ports.
module switch_out_port
    import switch_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int MAX_PKTS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [7:0]  port_out,
    output logic        port_ready,
    input  logic        port_read
`ifdef SWITCH_OUT_PORT_STATS_EN
    ,
    output logic [15:0] stat_pkts,
    output logic [31:0] stat_bytes
`endif
);

    localparam int                 CNT_W   = $clog2(MAX_PKTS + 1);
    localparam logic [CNT_W-1:0]   MAX_CNT = CNT_W'(MAX_PKTS);

    out_state_e       state;
    out_state_e       state_nxt;
    logic [CNT_W-1:0] pkt_cnt;
    fifo_ent_t        wr_ent;
    fifo_ent_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             wr_en;
    logic             wr_last;
    logic             rd_en;
    logic             rd_last;

    // Backpressure depends on registered state only, so a pop in this
    // cycle cannot open in_ready in the same cycle.
    assign in_ready = !fifo_full && (pkt_cnt < MAX_CNT);
    assign wr_en    = in_valid && in_ready;
    assign wr_last  = wr_en && in_last;
    assign wr_ent   = {in_last, in_data};
    assign rd_last  = rd_en && head.last;

    assign port_ready = (state == OFFER);

    sync_fifo #(
        .WIDTH ($bits(fifo_ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_en),
        .wdata (wr_ent),
        .pop   (rd_en),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Egress FSM next state and pop decision.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pkt_cnt != '0) begin
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (port_read && !fifo_empty) begin
                    rd_en = 1'b1;
                    if (head.last) begin
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register and registered output byte (held until the next pop).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            port_out <= '0;
        end else begin
            state <= state_nxt;
            if (rd_en) begin
                port_out <= head.data;
            end
        end
    end

    // Complete-packet counter; a simultaneous last-write and last-read cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt <= '0;
        end else begin
            unique case ({wr_last, rd_last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

`ifdef SWITCH_OUT_PORT_STATS_EN
    // Free-running statistics; both counters wrap silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pkts  <= '0;
            stat_bytes <= '0;
        end else begin
            if (rd_en) begin
                stat_bytes <= stat_bytes + 1'b1;
            end
            if (rd_last) begin
                stat_pkts <= stat_pkts + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_switch_out_port.sv
// Scoreboard bench for switch_out_port.
// Every byte written from the fabric side is queued with its last flag.
// A monitor pops and compares each time the DUT pops a byte onto port_out.
// Directed sequences also compare port_ready traces against hand-derived patterns.
module tb_switch_out_port;

    typedef struct packed {
        logic       v;
        logic       l;
        logic [7:0] d;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [7:0]  port_out;
    logic        port_ready;
    logic        port_read = 1'b0;
`ifdef SWITCH_OUT_PORT_STATS_EN
    logic [15:0] stat_pkts;
    logic [31:0] stat_bytes;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic pending = 1'b0;

    switch_out_port #(
        .DEPTH    (64),
        .MAX_PKTS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .port_out   (port_out),
        .port_ready (port_ready),
        .port_read  (port_read)
`ifdef SWITCH_OUT_PORT_STATS_EN
        ,
        .stat_pkts  (stat_pkts),
        .stat_bytes (stat_bytes)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop sampled at one edge shows on port_out until the next edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("port_out", port_out, e.data);
                    check("ready_after_pop", port_ready, !e.last);
                end
            end
            pending = port_ready && port_read;
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        port_read = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_port_ready"}, port_ready, 0);
        check({tag, "_port_out"}, port_out, 8'h00);
        check({tag, "_in_ready"}, in_ready, 1);
`ifdef SWITCH_OUT_PORT_STATS_EN
        check({tag, "_stat_pkts"}, stat_pkts, 0);
        check({tag, "_stat_bytes"}, stat_bytes, 0);
`endif
    endtask

    // One write slot per cycle with port_read held high; records port_ready
    // as seen after each edge (MSB = first cycle).
    task automatic run_seq(input wr_t s [12], output logic [11:0] samp);
        exp_t e;
        port_read = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = s[c].v;
            in_last  = s[c].l;
            in_data  = s[c].d;
            if (s[c].v) begin
                e.data = s[c].d;
                e.last = s[c].l;
                sb.push_back(e);
            end
            @(negedge clk);
            samp[11-c] = port_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        port_read = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_drain"}, sb.size(), 0);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!port_ready && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_ready_wait"}, port_ready, 1);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic l);
        exp_t e;
        in_valid = 1'b1;
        in_last  = l;
        in_data  = d;
        e.data   = d;
        e.last   = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        wr_t         s [12];
        logic [11:0] samp;
        logic [11:0] exp_samp;
        int          not_ready;

        // 1) reset state, port_read ignored while nothing is offered
        do_reset();
        check_idle_outputs("reset");
        port_read = 1'b1;
        @(posedge clk);
        #1;
        port_read = 1'b0;
        @(posedge clk);
        #1;
        check("idle_read_ready", port_ready, 0);
        check("idle_read_out", port_out, 8'h00);

        // 2) 4-byte packet, ready rises 2nd cycle after A4, falls with A4
        s = '{0: '{1'b1, 1'b0, 8'hA1}, 1: '{1'b1, 1'b0, 8'hA2}, 2: '{1'b1, 1'b0, 8'hA3},
              3: '{1'b1, 1'b1, 8'hA4}, default: '0};
        run_seq(s, samp);
        exp_samp = 12'b000001111000;
        check("pkt4_ready_trace", samp, exp_samp);
        drain("pkt4", 10);

        // 3) 3-byte packet then 1-byte packet back to back
        s = '{0: '{1'b1, 1'b0, 8'hB1}, 1: '{1'b1, 1'b0, 8'hB2}, 2: '{1'b1, 1'b1, 8'hB3},
              3: '{1'b1, 1'b1, 8'hC1}, default: '0};
        run_seq(s, samp);
        exp_samp = 12'b000011100100;
        check("b2b_ready_trace", samp, exp_samp);
        drain("b2b", 10);
`ifdef SWITCH_OUT_PORT_STATS_EN
        check("stats_pkts_3", stat_pkts, 3);
        check("stats_bytes_8", stat_bytes, 8);
`endif

        // 4) fill FIFO without a last byte: backpressure, no offer, reset clears
        not_ready = 0;
        for (int i = 0; i < 64; i++) begin
            if (!in_ready) not_ready++;
            in_valid = 1'b1;
            in_last  = 1'b0;
            in_data  = 8'(i);
            @(posedge clk);
            #1;
        end
        check("fill_accepting", not_ready, 0);
        check("full_in_ready", in_ready, 0);
        check("full_port_ready", port_ready, 0);
        in_data = 8'hEE;
        repeat (3) @(posedge clk);
        #1;
        check("full_hold_in_ready", in_ready, 0);
        in_valid = 1'b0;
        do_reset();
        check_idle_outputs("after_fill");

        // 4b) packet-count limit: 8 single-byte packets close in_ready
        for (int i = 0; i < 8; i++) begin
            write_byte(8'h30 + 8'(i), 1'b1);
            if (i == 6) check("pkts7_in_ready", in_ready, 1);
        end
        check("pkts8_in_ready", in_ready, 0);
        port_read = 1'b1;
        drain("pkts8", 200);
        port_read = 1'b0;

        // 5) last write coincides with last pop of previous packet
        s = '{0: '{1'b1, 1'b0, 8'hE1}, 1: '{1'b1, 1'b1, 8'hE2}, 2: '{1'b1, 1'b0, 8'hF1},
              4: '{1'b1, 1'b1, 8'hF2}, default: '0};
        run_seq(s, samp);
        exp_samp = 12'b000110011000;
        check("coincide_ready_trace", samp, exp_samp);
        drain("coincide", 10);

        // 6) reset mid-read after 2 of 5 bytes
        do_reset();
        for (int i = 0; i < 5; i++) begin
            write_byte(8'h51 + 8'(i), i == 4);
        end
        wait_ready("mid", 10);
        port_read = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        port_read = 1'b0;
        @(negedge clk);
        #1;
        check("mid_popped_two", sb.size(), 3);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_reset_no_stale", port_ready, 0);
        write_byte(8'h99, 1'b1);
        port_read = 1'b1;
        drain("post_reset", 10);
        port_read = 1'b0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
